// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives pipeline-register enables and clears,
// arbitrates the shared memory port, detects load-use hazards and counts cycles and stalls.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memREN,
    input  logic             memWEN,
    input  logic [REG_W-1:0] idrsel1,
    input  logic [REG_W-1:0] idrsel2,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exDest,
    input  logic             exBranchTaken,
    input  logic             idJump,
    input  logic             wbHalt,
    output logic             pcW,
    output logic             ifW,
    output logic             ifRST,
    output logic             idW,
    output logic             idRST,
    output logic             exW,
    output logic             exRST,
    output logic             memW,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycCnt;
    logic [CNT_W-1:0] r_stallCnt;

    logic w_memBusy;
    logic w_loadUse;
    logic w_issue;

    assign w_memBusy = memREN | memWEN;
    assign w_loadUse = exMemRead && (exDest != '0) &&
                       ((exDest == idrsel1) || (exDest == idrsel2));

    // Cycles in which the pipeline moves: RUN without a halt or an unfinished data access,
    // or the release cycle of a data wait.
    assign w_issue = ((r_state == RUN) && !wbHalt && !(w_memBusy && !dhit)) ||
                     ((r_state == DWAIT) && dhit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_halted <= (w_nextState == HALT);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (wbHalt)
                    w_nextState = HALT;
                else if (w_memBusy && !dhit)
                    w_nextState = DWAIT;
            end
            DWAIT: begin
                if (dhit)
                    w_nextState = RUN;
            end
            HALT:    w_nextState = HALT;
            default: w_nextState = RUN;
        endcase
    end

    always_comb begin
        pcW   = 1'b0;
        ifW   = 1'b0;
        ifRST = 1'b0;
        idW   = 1'b0;
        idRST = 1'b0;
        exW   = 1'b0;
        exRST = 1'b0;
        memW  = 1'b0;
        if (!RST && w_issue) begin
            pcW  = ihit;
            ifW  = 1'b1;
            idW  = 1'b1;
            exW  = 1'b1;
            memW = 1'b1;
            // A taken branch squashes both younger slots, which makes any load-use stall moot.
            if (exBranchTaken) begin
                pcW   = 1'b1;
                ifRST = 1'b1;
                idRST = 1'b1;
            end else if (w_loadUse) begin
                pcW   = 1'b0;
                ifW   = 1'b0;
                idRST = 1'b1;
            end else if (idJump) begin
                ifRST = 1'b1;
            end else if (!ihit && !w_memBusy) begin
                ifRST = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycCnt   <= '0;
            r_stallCnt <= '0;
        end else if (r_state != HALT) begin
            r_cycCnt <= r_cycCnt + 1'b1;
            if (!pcW)
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign halted    = r_halted;
    assign cyc_cnt   = r_cycCnt;
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level reference model checked every negedge,
// plus literal expectations at the interesting points of each scenario.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       ihit;
        logic       dhit;
        logic       memREN;
        logic       memWEN;
        logic [4:0] idrsel1;
        logic [4:0] idrsel2;
        logic       exMemRead;
        logic [4:0] exDest;
        logic       exBranchTaken;
        logic       idJump;
        logic       wbHalt;
    } stim_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, memREN = 1'b0, memWEN = 1'b0;
    logic [4:0]  idrsel1 = '0, idrsel2 = '0, exDest = '0;
    logic        exMemRead = 1'b0, exBranchTaken = 1'b0, idJump = 1'b0, wbHalt = 1'b0;
    logic        pcW, ifW, ifRST, idW, idRST, exW, exRST, memW, halted;
    logic [31:0] cyc_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: waiting on data, halted, and the two counters.
    logic        mWait = 1'b0, mHalt = 1'b0;
    logic [31:0] mCyc = '0, mStall = '0;
    logic        mBusy, mHazard, mMoving;
    logic [7:0]  mExp;
    logic [7:0]  dutOuts;

    hazard_ctrl #(.CNT_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .memREN(memREN), .memWEN(memWEN),
        .idrsel1(idrsel1), .idrsel2(idrsel2), .exMemRead(exMemRead), .exDest(exDest),
        .exBranchTaken(exBranchTaken), .idJump(idJump), .wbHalt(wbHalt),
        .pcW(pcW), .ifW(ifW), .ifRST(ifRST), .idW(idW), .idRST(idRST), .exW(exW),
        .exRST(exRST), .memW(memW), .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge CLK);
        #1;
        RST = s.rst; ihit = s.ihit; dhit = s.dhit; memREN = s.memREN; memWEN = s.memWEN;
        idrsel1 = s.idrsel1; idrsel2 = s.idrsel2; exMemRead = s.exMemRead; exDest = s.exDest;
        exBranchTaken = s.exBranchTaken; idJump = s.idJump; wbHalt = s.wbHalt;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    // Output vector order: {pcW, ifW, ifRST, idW, idRST, exW, exRST, memW}
    assign dutOuts = {pcW, ifW, ifRST, idW, idRST, exW, exRST, memW};

    always @(negedge CLK) begin
        if (RST) begin
            checkOutput("rstOutputs", {24'd0, dutOuts}, 32'd0);
            checkOutput("rstHalted", {31'd0, halted}, 32'd0);
            checkOutput("rstCyc", cyc_cnt, 32'd0);
            checkOutput("rstStall", stall_cnt, 32'd0);
            mWait = 1'b0; mHalt = 1'b0; mCyc = '0; mStall = '0;
        end else begin
            mBusy   = memREN | memWEN;
            mHazard = exMemRead && (exDest != 5'd0) && (exDest == idrsel1 || exDest == idrsel2);
            mMoving = !mHalt && !(!mWait && wbHalt) && !((mWait || mBusy) && !dhit);
            mExp = 8'h00;
            if (mMoving) begin
                mExp[7] = exBranchTaken ? 1'b1 : (mHazard ? 1'b0 : ihit);
                mExp[6] = exBranchTaken || !mHazard;
                mExp[5] = exBranchTaken || (!mHazard && (idJump || (!ihit && !mBusy)));
                mExp[4] = 1'b1;
                mExp[3] = exBranchTaken || mHazard;
                mExp[2] = 1'b1;
                mExp[1] = 1'b0;
                mExp[0] = 1'b1;
            end
            checkOutput("outputs", {24'd0, dutOuts}, {24'd0, mExp});
            checkOutput("halted", {31'd0, halted}, {31'd0, mHalt});
            checkOutput("cycCnt", cyc_cnt, mCyc);
            checkOutput("stallCnt", stall_cnt, mStall);
            if (!mHalt) begin
                mCyc = mCyc + 1;
                if (!mExp[7]) mStall = mStall + 1;
                if (!mWait && wbHalt) mHalt = 1'b1;
                else if ((mWait || mBusy) && !dhit) mWait = 1'b1;
                else mWait = 1'b0;
            end
        end
    end

    initial begin
        stim_t idle, s;
        logic [31:0] c0, s0;
        idle = '0;
        idle.ihit = 1'b1;
        s = idle;
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        // Five running cycles after release: the counter must read four edges later.
        for (int i = 0; i < 5; i++) applyStimulus(idle);
        checkOutput("cycAfterRelease", cyc_cnt, 32'd4);
        checkOutput("stallAfterRelease", stall_cnt, 32'd0);

        // Reset pulse in the middle of a data wait.
        s = idle; s.memREN = 1'b1; s.dhit = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        settle();
        checkOutput("dwaitFrozen", {31'd0, ifW}, 32'd0);
        s.rst = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("rstPulsePcW", {31'd0, pcW}, 32'd0);
        checkOutput("rstPulseCyc", cyc_cnt, 32'd0);
        applyStimulus(idle);
        settle();
        checkOutput("postRstPcW", {31'd0, pcW}, 32'd1);
        checkOutput("postRstIfW", {31'd0, ifW}, 32'd1);

        // Load-use hazard lasts exactly one cycle; register 0 never hazards.
        s = idle; s.exMemRead = 1'b1; s.exDest = 5'd5; s.idrsel2 = 5'd5;
        applyStimulus(s);
        settle();
        checkOutput("luPcW", {31'd0, pcW}, 32'd0);
        checkOutput("luIfW", {31'd0, ifW}, 32'd0);
        checkOutput("luIdRST", {31'd0, idRST}, 32'd1);
        checkOutput("luExW", {31'd0, exW}, 32'd1);
        applyStimulus(idle);
        settle();
        checkOutput("luAfterPcW", {31'd0, pcW}, 32'd1);
        s = idle; s.exMemRead = 1'b1; s.exDest = 5'd0; s.idrsel1 = 5'd0;
        applyStimulus(s);
        settle();
        checkOutput("luZeroPcW", {31'd0, pcW}, 32'd1);
        checkOutput("luZeroIdRST", {31'd0, idRST}, 32'd0);

        // Three-cycle data wait then release with a fetch hit.
        s = idle; s.memREN = 1'b1; s.dhit = 1'b0;
        applyStimulus(s);
        s0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) applyStimulus(s);
            settle();
            checkOutput("dwaitAllW", {28'd0, ifW, idW, exW, memW}, 32'd0);
        end
        s.dhit = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("releaseAllW", {28'd0, ifW, idW, exW, memW}, 32'hF);
        applyStimulus(idle);
        checkOutput("dwaitStallDelta", stall_cnt - s0, 32'd3);

        // Branch overrides a simultaneous load-use hazard.
        s = idle; s.exBranchTaken = 1'b1; s.exMemRead = 1'b1; s.exDest = 5'd3; s.idrsel1 = 5'd3;
        applyStimulus(s);
        settle();
        checkOutput("brLuOuts", {28'd0, pcW, ifW, ifRST, idRST}, 32'hF);

        // Store stall with a branch held in EX: freeze first, squash on release.
        s = idle; s.memWEN = 1'b1; s.dhit = 1'b0; s.exBranchTaken = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("stFreezeOuts", {28'd0, pcW, ifW, ifRST, idRST}, 32'h0);
        applyStimulus(s);
        s.dhit = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("stReleaseOuts", {29'd0, pcW, ifRST, idRST}, 32'h7);
        applyStimulus(idle);
        settle();
        checkOutput("stBackToRun", {30'd0, pcW, ifRST}, 32'h2);

        // Jump squash and plain fetch miss.
        s = idle; s.idJump = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("jumpOuts", {30'd0, pcW, ifRST}, 32'h3);
        s = idle; s.ihit = 1'b0;
        applyStimulus(s);
        settle();
        checkOutput("imissOuts", {29'd0, pcW, ifW, ifRST}, 32'h3);

        // Halt freezes everything until reset.
        s = idle; s.wbHalt = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("haltCycleOuts", {24'd0, dutOuts}, 32'd0);
        applyStimulus(idle);
        checkOutput("haltedSet", {31'd0, halted}, 32'd1);
        c0 = cyc_cnt;
        s0 = stall_cnt;
        for (int i = 0; i < 10; i++) applyStimulus(idle);
        checkOutput("haltCycFrozen", cyc_cnt, c0);
        checkOutput("haltStallFrozen", stall_cnt, s0);
        checkOutput("haltedStill", {31'd0, halted}, 32'd1);
        s = idle; s.rst = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("haltedCleared", {31'd0, halted}, 32'd0);
        applyStimulus(idle);
        applyStimulus(idle);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable (W) and synchronous-clear (RST) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC write-enable.
- Arbitrates the single shared memory port (data access has priority over fetch) and detects load-use hazards.
- Keeps cycle and stall counters for performance measurement.

Parameters:
CNT_W, 32, width of cycle and stall counters
REG_W, 5, register-select width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
memREN  in  1  MEM-stage load pending
memWEN  in  1  MEM-stage store pending
idrsel1  in  REG_W  ID-stage source register 1
idrsel2  in  REG_W  ID-stage source register 2
exMemRead  in  1  EX-stage instruction is a load
exDest  in  REG_W  EX-stage destination register
exBranchTaken  in  1  EX resolved a taken branch or JR
idJump  in  1  ID holds J or JAL
wbHalt  in  1  HALT reached MEM/WB
pcW  out  1  PC write-enable
ifW, ifRST  out  1,1  IF/ID enable, IF/ID clear
idW, idRST  out  1,1  ID/EX enable, ID/EX clear
exW, exRST  out  1,1  EX/MEM enable, EX/MEM clear
memW  out  1  MEM/WB enable
halted  out  1  pipeline halted (registered)
cyc_cnt  out  CNT_W  cycles since reset, excluding HALT
stall_cnt  out  CNT_W  cycles with pcW=0, excluding HALT

Behaviour:
- Reset (asynchronous, may arrive mid-operation): state=RUN, halted=0, counters=0.
  - While RST=1, all W and all clear outputs are 0.
  - A pending data wait is abandoned. No memory handshake state is retained.
- States:
  - RUN: normal issue.
  - DWAIT: MEM-stage data access outstanding.
  - HALT: terminal until RST.
- Outputs are combinational from the registered state and current inputs. The state register, halted and the counters are registered.
- Default in RUN: all W=1, all clears=0, pcW=ihit.
- RUN priority, highest first:
  1. wbHalt=1: all W=0 and pcW=0. Next state HALT; halted=1 from the next cycle.
  2. (memREN|memWEN) and !dhit: all W=0 and pcW=0 (freeze). Next state DWAIT. ihit is ignored (port busy).
  3. (memREN|memWEN) and dhit: all W=1 and pcW=ihit. Stay in RUN.
  4. exBranchTaken: pcW=1, ifRST=1, idRST=1. Squashes both younger instructions and overrides load-use and idJump.
  5. Load-use: exMemRead, exDest!=0, and exDest equals idrsel1 or idrsel2.
     - pcW=0, ifW=0, idRST=1 (bubble into EX). exW and memW stay 1.
     - Lasts one cycle, since the load advances to MEM.
  6. idJump: pcW=ihit, ifRST=1 (one-slot squash).
  7. !ihit with no data access: pcW=0 and ifRST=1 (bubble into ID). Other W=1.
- Rules 5 and 7 together: the load-use outputs apply (pcW=0, ifW=0, idRST=1).
- Rules 4 and 7 together: pcW=1 and clears as rule 4; the fetch miss is irrelevant.
- DWAIT:
  - While !dhit: all W=0 and pcW=0; all inputs are held frozen by the upstream stages.
  - On dhit=1: outputs follow RUN rules 3–7 for that cycle, then next state RUN. A branch held in EX during the wait is applied on the release cycle.
  - wbHalt cannot arise in DWAIT because MEM/WB is frozen.
- HALT: all W=0, pcW=0, clears=0, halted=1. Counters frozen.
- Counters:
  - cyc_cnt increments every non-reset cycle with state!=HALT.
  - stall_cnt increments in those cycles when pcW=0.
  - Both wrap modulo 2^CNT_W. A cycle's increment is visible on the next edge.

Test Plan:
- RST pulse while in DWAIT (memREN=1, dhit=0) → state RUN, cyc_cnt=0, all outputs 0 during RST; after release with ihit=1 and no hazards → pcW=1, ifW=1.
- exMemRead=1, exDest=5, idrsel2=5, ihit=1 → exactly one cycle with pcW=0, ifW=0, idRST=1, exW=1. With exDest=0 and idrsel1=0 → no stall.
- memREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with all W=0; 4th cycle all W=1; stall_cnt advanced by 3 (plus 1 if ihit=0 on the release cycle).
- exBranchTaken=1 and load-use hazard in the same cycle → pcW=1, ifRST=1, idRST=1, ifW=1.
- memWEN=1, dhit=0, exBranchTaken=1 → freeze (no clears). Release cycle with dhit=1 → ifRST=1, idRST=1, pcW=1; state RUN.
- wbHalt=1 → next cycle halted=1 and all W=0; 10 further cycles leave cyc_cnt and stall_cnt unchanged; RST → halted=0.
